// File: rtl/rr_encoder32_5.sv
// Registered 32-to-5 round-robin request encoder with valid/ready output and a one-cycle grant.
// Collapses multi-hot requests into one 5-bit index, one capture per accepted transfer.
module rr_encoder32_5 #(
  parameter int DELAY = 50,
  parameter bit RR    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e,
  input  logic [31:0] req,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  idx,
  output logic [31:0] grant
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]  state_reg, state_next;
  logic [4:0]  idx_reg, idx_next;
  logic [31:0] grant_reg, grant_next;
  logic [4:0]  ptr_reg, ptr_next;

  logic [31:0] rot;
  logic [4:0]  offset;
  logic [4:0]  winner;
  logic        load;

  // DELAY only annotates clk-to-q in behavioural models; the registers here carry none.
  generate
    if (DELAY < 0) begin : g_negative_delay
    end
  endgenerate

  // Rotate requests so bit 0 is the highest-priority candidate.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rot
      if (RR) begin : g_rr
        assign rot[gi] = req[ptr_reg + 5'(gi)];
      end else begin : g_fixed
        assign rot[gi] = req[gi];
      end
    end
  endgenerate

  always_comb begin
    offset = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (rot[i]) offset = 5'(i);
    end
  end

  assign winner = RR ? (ptr_reg + offset) : offset;
  assign load   = e & (|req) & ((state_reg == IDLE) | out_ready);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    grant_next = 32'd0;
    ptr_next   = ptr_reg;
    if (load) begin
      state_next = HOLD;
      idx_next   = winner;
      grant_next = 32'd1 << winner;
      ptr_next   = winner + 5'd1;
    end else if ((state_reg == HOLD) && out_ready) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= 5'd0;
      grant_reg <= 32'd0;
      ptr_reg   <= 5'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign out_valid = (state_reg == HOLD);
  assign idx       = idx_reg;
  assign grant     = grant_reg;

endmodule

// File: tb/tb_rr_encoder32_5.sv
// Checks a round-robin and a fixed-priority rr_encoder32_5 against a queue-free behavioural model.
// Directed scenarios first, then a randomized run with occasional resets.
module tb_rr_encoder32_5;

  logic        clk = 1'b0;
  logic        rst;
  logic        e;
  logic [31:0] req;
  logic        out_ready;

  logic        v_rr, v_fx;
  logic [4:0]  i_rr, i_fx;
  logic [31:0] g_rr, g_fx;

  int passed = 0;
  int total  = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  logic        m_valid [2];
  logic [4:0]  m_idx   [2];
  logic [31:0] m_grant [2];
  int          m_ptr   [2];

  always #5 clk = ~clk;

  rr_encoder32_5 #(.DELAY(50), .RR(1'b1)) dut_rr (
    .clk(clk), .reset(rst), .e(e), .req(req), .out_ready(out_ready),
    .out_valid(v_rr), .idx(i_rr), .grant(g_rr)
  );

  rr_encoder32_5 #(.DELAY(0), .RR(1'b0)) dut_fx (
    .clk(clk), .reset(rst), .e(e), .req(req), .out_ready(out_ready),
    .out_valid(v_fx), .idx(i_fx), .grant(g_fx)
  );

  // First requesting source when scanning upward from start, wrapping modulo 32.
  function automatic int pick(input logic [31:0] r, input int start);
    for (int k = 0; k < 32; k++) begin
      if (r[(start + k) % 32]) return (start + k) % 32;
    end
    return -1;
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit ld;
      int w;
      ld = e && (req != 32'd0) && (!m_valid[m] || out_ready);
      if (rst) begin
        m_valid[m] = 1'b0; m_idx[m] = 5'd0; m_grant[m] = 32'd0; m_ptr[m] = 0;
      end else begin
        m_grant[m] = 32'd0;
        if (ld) begin
          w = pick(req, (m == 0) ? m_ptr[m] : 0);
          m_valid[m] = 1'b1;
          m_idx[m]   = 5'(w);
          m_grant[m] = 32'd1 << w;
          m_ptr[m]   = (w + 1) % 32;
        end else if (m_valid[m] && out_ready) begin
          m_valid[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: apply inputs, advance model on the edge, compare 1 time unit later.
  task automatic step(input string tag, input logic r, input logic en,
                      input logic [31:0] rq, input logic rdy);
    rst = r; e = en; req = rq; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_rr_valid"}, 32'(v_rr), 32'(m_valid[0]));
    chk({tag, "_rr_idx"},   32'(i_rr), 32'(m_idx[0]));
    chk({tag, "_rr_grant"}, g_rr,      m_grant[0]);
    chk({tag, "_fx_valid"}, 32'(v_fx), 32'(m_valid[1]));
    chk({tag, "_fx_idx"},   32'(i_fx), 32'(m_idx[1]));
    chk({tag, "_fx_grant"}, g_fx,      m_grant[1]);
    $display("%s rst=%0b e=%0b req=%h rdy=%0b | rr v=%0b idx=%0d g=%h | fx v=%0b idx=%0d g=%h",
             tag, r, en, rq, rdy, v_rr, i_rr, g_rr, v_fx, i_fx, g_fx);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0; m_idx[m] = 5'd0; m_grant[m] = 32'd0; m_ptr[m] = 0;
    end
    rst = 1'b1; e = 1'b0; req = 32'd0; out_ready = 1'b0;
    #2;

    // T1: reset dominates a full request vector.
    step("t1", 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("t1_valid_lit", 32'(v_rr), 32'd0);
    chk("t1_grant_lit", g_rr, 32'd0);

    // T2: single request.
    step("t2", 1'b0, 1'b1, 32'h0000_0400, 1'b1);
    chk("t2_idx_lit", 32'(i_rr), 32'd10);
    chk("t2_grant_lit", g_rr, 32'h0000_0400);

    // T3: rotation with wrap, starting from a fresh pointer.
    step("t3_rst", 1'b1, 1'b0, 32'd0, 1'b0);
    step("t3a", 1'b0, 1'b1, 32'h8000_0005, 1'b1);
    chk("t3a_idx_lit", 32'(i_rr), 32'd0);
    step("t3b", 1'b0, 1'b1, 32'h8000_0005, 1'b1);
    chk("t3b_idx_lit", 32'(i_rr), 32'd2);
    step("t3c", 1'b0, 1'b1, 32'h8000_0005, 1'b1);
    chk("t3c_idx_lit", 32'(i_rr), 32'd31);
    step("t3d", 1'b0, 1'b1, 32'h8000_0005, 1'b1);
    chk("t3d_idx_lit", 32'(i_rr), 32'd0);
    chk("t6_fx_idx_lit", 32'(i_fx), 32'd0);

    // T4: backpressure holds idx; req changes are ignored until accepted.
    step("t4_rst", 1'b1, 1'b0, 32'd0, 1'b0);
    step("t4_cap", 1'b0, 1'b1, 32'h0000_0008, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step("t4_hold", 1'b0, 1'b1, 32'h0000_0010, 1'b0);
      chk("t4_hold_idx_lit", 32'(i_rr), 32'd3);
      chk("t4_hold_grant_lit", g_rr, 32'd0);
    end
    step("t4_go", 1'b0, 1'b1, 32'h0000_0010, 1'b1);
    chk("t4_go_idx_lit", 32'(i_rr), 32'd4);

    // T5: enable low drains to IDLE; reset drops a held index.
    step("t5_rst", 1'b1, 1'b0, 32'd0, 1'b0);
    step("t5_cap", 1'b0, 1'b1, 32'h0000_0080, 1'b1);
    step("t5_e0", 1'b0, 1'b0, 32'h0000_0080, 1'b1);
    chk("t5_idle_lit", 32'(v_rr), 32'd0);
    step("t5_cap2", 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    step("t5_rst2", 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    chk("t5_rst_valid_lit", 32'(v_rr), 32'd0);
    step("t5_after", 1'b0, 1'b1, 32'h8000_0001, 1'b1);
    chk("t5_ptr0_idx_lit", 32'(i_rr), 32'd0);

    // req=0 with handshake completing drops to IDLE.
    step("t7_zero", 1'b0, 1'b1, 32'd0, 1'b1);

    // Randomized run.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rq;
      case ($urandom_range(0, 3))
        0: rq = $urandom;
        1: rq = 32'd1 << $urandom_range(0, 31);
        2: rq = 32'd0;
        default: rq = $urandom & $urandom & $urandom;
      endcase
      step("rnd", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rq,
           ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
